// File: rtl/comm_pkg.sv
// Shared types and constants for the CW305 <-> PULPino word mailbox.
package comm_pkg;

    localparam int unsigned COMM_WORD_W        = 32;
    localparam int unsigned COMM_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } comm_state_e;

endpackage

// File: rtl/comm_sync_fifo.sv
// Single-clock FIFO with a registered head word, registered full/empty/count flags,
// and a combinational overflow pulse that fires when a push is dropped.
module comm_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        overflow_c = push && full && !do_pop;
        count_nxt  = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
            // Head tracks the oldest entry; bypass the pushed word when it becomes the head.
            if (do_pop) begin
                if (count == CW'(1)) begin
                    if (do_push) begin
                        head <= push_data;
                    end
                end else begin
                    head <= mem[rd_ptr + AW'(1)];
                end
            end else if (empty && do_push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/comm_word_mailbox.sv
// Word mailbox between the CW305 USB register file and the PULPino GPIO serialiser.
// Optional WAIT_DONE watchdog enabled by defining COMM_MAILBOX_TIMEOUT_EN.
module comm_word_mailbox
    import comm_pkg::*;
#(
    parameter int unsigned DEPTH          = COMM_DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    tx_wr_i,
    input  logic [COMM_WORD_W-1:0]  tx_data_i,
    output logic                    tx_full_o,
    output logic [$clog2(DEPTH):0]  tx_count_o,
    input  logic                    rx_rd_i,
    output logic [COMM_WORD_W-1:0]  rx_data_o,
    output logic                    rx_empty_o,
    output logic [$clog2(DEPTH):0]  rx_count_o,
    input  logic                    clear_err_i,
    output logic                    tx_overflow_o,
    output logic                    rx_overflow_o,
    output logic                    timeout_o,
    output logic                    busy_o,
    output logic [COMM_WORD_W-1:0]  read_data_o,
    output logic                    do_read_o,
    input  logic                    data_in_done_i,
    input  logic [COMM_WORD_W-1:0]  write_data_i,
    input  logic                    data_out_done_i
);

    comm_state_e            state;
    logic                   in_snap;
    logic                   out_prev;
    logic [COMM_WORD_W-1:0] tx_head;
    logic                   tx_empty;
    logic                   tx_pop;
    logic                   tx_ovf_c;
    logic                   rx_push;
    logic                   rx_ovf_c;
    logic                   rx_full_unused;

    assign tx_pop  = (state == IDLE) && !tx_empty;
    assign rx_push = (data_out_done_i != out_prev);

    comm_sync_fifo #(.WIDTH(COMM_WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .push       (tx_wr_i),
        .push_data  (tx_data_i),
        .pop        (tx_pop),
        .head       (tx_head),
        .full       (tx_full_o),
        .empty      (tx_empty),
        .count      (tx_count_o),
        .overflow_c (tx_ovf_c)
    );

    comm_sync_fifo #(.WIDTH(COMM_WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .push       (rx_push),
        .push_data  (write_data_i),
        .pop        (rx_rd_i),
        .head       (rx_data_o),
        .full       (rx_full_unused),
        .empty      (rx_empty_o),
        .count      (rx_count_o),
        .overflow_c (rx_ovf_c)
    );

    // Done-edge history and sticky FIFO error flags; a new error beats a clear.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_prev      <= 1'b0;
            tx_overflow_o <= 1'b0;
            rx_overflow_o <= 1'b0;
        end else begin
            out_prev <= data_out_done_i;
            if (tx_ovf_c) begin
                tx_overflow_o <= 1'b1;
            end else if (clear_err_i) begin
                tx_overflow_o <= 1'b0;
            end
            if (rx_ovf_c) begin
                rx_overflow_o <= 1'b1;
            end else if (clear_err_i) begin
                rx_overflow_o <= 1'b0;
            end
        end
    end

`ifdef COMM_MAILBOX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          timeout_q;

    assign timeout_o = timeout_q;

    // TX issue FSM with WAIT_DONE watchdog; an expired word is abandoned.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            read_data_o <= '0;
            do_read_o   <= 1'b0;
            busy_o      <= 1'b0;
            in_snap     <= 1'b0;
            tmo_cnt     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (clear_err_i) begin
                timeout_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        read_data_o <= tx_head;
                        in_snap     <= data_in_done_i;
                        do_read_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    do_read_o <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (data_in_done_i != in_snap) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        in_snap   <= data_in_done_i;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    do_read_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign timeout_o = 1'b0;

    // TX issue FSM: one word in flight, released by a data_in_done toggle.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            read_data_o <= '0;
            do_read_o   <= 1'b0;
            busy_o      <= 1'b0;
            in_snap     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        read_data_o <= tx_head;
                        in_snap     <= data_in_done_i;
                        do_read_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    do_read_o <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (data_in_done_i != in_snap) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    do_read_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule
